serial_bit_feeder: RTL and testbench

- Parallel-to-serial stage placed directly upstream of the bit-serial sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per enabled clock on sout, which drives the detector's in port.
- A one-word holding buffer lets back-to-back words stream with no bit gap.
- A step enable supports slow lab clocks and clock-divider ticks.

---
 rtl/serial_bit_feeder.sv | 107 ++++++++++
 tb/tb_serial_bit_feeder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the bit-serial sequence detector: accepts WIDTH-bit words
// over valid/ready and emits one bit per step cycle, with a one-word hold buffer for gapless streaming.
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         din,
  input  logic                     din_valid,
  output logic                     din_ready,
  input  logic                     step,
  output logic                     sout,
  output logic                     sout_valid,
  output logic                     busy,
  output logic [$clog2(WIDTH)-1:0] bit_idx
);

  localparam int RW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t            r_state, w_state;
  logic [WIDTH-1:0]  r_sh, w_sh;
  logic [WIDTH-1:0]  r_hd, w_hd;
  logic [RW-1:0]     r_rem, w_rem;
  logic              r_hold_full, w_hold_full;
  logic              r_sout, w_sout;
  logic              r_sout_valid, w_sout_valid;
  logic [IW-1:0]     r_bit_idx, w_bit_idx;

  logic              w_emit;
  logic              w_accept;
  logic              w_sh_free;

  always_comb begin
    w_state      = r_state;
    w_sh         = r_sh;
    w_hd         = r_hd;
    w_rem        = r_rem;
    w_hold_full  = r_hold_full;
    w_sout       = r_sout;
    w_sout_valid = 1'b0;
    w_bit_idx    = r_bit_idx;

    w_emit    = (r_state == S_SHIFT) && step;
    w_accept  = din_valid && !r_hold_full;
    // The shifter counts as free if it is empty now or its last bit leaves on this edge.
    w_sh_free = (r_rem == '0) || ((r_rem == RW'(1)) && step);

    if (w_emit) begin
      w_sout       = MSB_FIRST ? r_sh[WIDTH-1] : r_sh[0];
      w_sout_valid = 1'b1;
      w_bit_idx    = IW'(WIDTH - int'(r_rem));
      w_sh         = MSB_FIRST ? {r_sh[WIDTH-2:0], 1'b0} : {1'b0, r_sh[WIDTH-1:1]};
      w_rem        = r_rem - RW'(1);
      if ((r_rem == RW'(1)) && r_hold_full) begin
        w_sh        = r_hd;
        w_rem       = RW'(WIDTH);
        w_hold_full = 1'b0;
      end
    end

    // Accept never coincides with a hold transfer: din_ready is low while the hold is full.
    if (w_accept) begin
      if (w_sh_free) begin
        w_sh  = din;
        w_rem = RW'(WIDTH);
      end else begin
        w_hd        = din;
        w_hold_full = 1'b1;
      end
    end

    w_state = (w_rem != '0) ? S_SHIFT : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_sh         <= '0;
      r_hd         <= '0;
      r_rem        <= '0;
      r_hold_full  <= 1'b0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_bit_idx    <= '0;
    end else begin
      r_state      <= w_state;
      r_sh         <= w_sh;
      r_hd         <= w_hd;
      r_rem        <= w_rem;
      r_hold_full  <= w_hold_full;
      r_sout       <= w_sout;
      r_sout_valid <= w_sout_valid;
      r_bit_idx    <= w_bit_idx;
    end
  end

  assign din_ready  = !r_hold_full;
  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign busy       = (r_rem != '0) || r_hold_full;
  assign bit_idx    = r_bit_idx;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: MSB-first and LSB-first instances share stimulus and are
// compared every cycle against a queue-of-pending-bits model, plus literal word checks.
module tb_serial_bit_feeder;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         step = 1'b0;

  logic         m_ready, m_sout, m_sv, m_busy;
  logic [2:0]   m_idx;
  logic         l_ready, l_sout, l_sv, l_busy;
  logic [2:0]   l_idx;

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(m_ready),
    .step(step), .sout(m_sout), .sout_valid(m_sv), .busy(m_busy), .bit_idx(m_idx));

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(l_ready),
    .step(step), .sout(l_sout), .sout_valid(l_sv), .busy(l_busy), .bit_idx(l_idx));

  int n_checks = 0;
  int n_err = 0;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: the bits still to be sent, in transmission order. Anything beyond
  // one word's worth in the queue is the held word.
  logic q_bit_m[$];
  logic q_bit_l[$];
  int   q_idx[$];
  logic e_sout_m = 1'b0, e_sout_l = 1'b0, e_sv = 1'b0;
  int   e_idx = 0;
  logic e_acc;

  always @(posedge clk) begin
    if (!reset) begin
      q_bit_m.delete(); q_bit_l.delete(); q_idx.delete();
      e_sout_m = 1'b0; e_sout_l = 1'b0; e_sv = 1'b0; e_idx = 0;
    end else begin
      e_acc = din_valid && (q_idx.size() <= W);
      e_sv  = 1'b0;
      if (step && q_idx.size() > 0) begin
        e_sout_m = q_bit_m.pop_front();
        e_sout_l = q_bit_l.pop_front();
        e_idx    = q_idx.pop_front();
        e_sv     = 1'b1;
      end
      if (e_acc) begin
        for (int i = 0; i < W; i++) begin
          q_bit_m.push_back(din[W-1-i]);
          q_bit_l.push_back(din[i]);
          q_idx.push_back(i);
        end
      end
    end
  end

  // Per-cycle comparison plus collectors used by the directed literal checks.
  logic        chk_en = 1'b0;
  logic [15:0] col_m = '0, col_l = '0;
  int          cnt_sv = 0, cnt_nr = 0, cyc = 0, first_sv = -1, last_sv = -1;

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      check("sout_msb",   m_sout, e_sout_m);
      check("sout_lsb",   l_sout, e_sout_l);
      check("valid_msb",  m_sv,   e_sv);
      check("valid_lsb",  l_sv,   e_sv);
      check("idx_msb",    m_idx,  e_idx);
      check("idx_lsb",    l_idx,  e_idx);
      check("busy_msb",   m_busy, int'(q_idx.size() > 0));
      check("busy_lsb",   l_busy, int'(q_idx.size() > 0));
      check("ready_msb",  m_ready, int'(q_idx.size() <= W));
      check("ready_lsb",  l_ready, int'(q_idx.size() <= W));
      if (m_sv) begin
        col_m = {col_m[14:0], m_sout};
        col_l = {col_l[14:0], l_sout};
        cnt_sv++;
        if (first_sv < 0) first_sv = cyc;
        last_sv = cyc;
      end
      if (!m_ready) cnt_nr++;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cols();
    col_m = '0; col_l = '0; cnt_sv = 0; cnt_nr = 0; first_sv = -1; last_sv = -1;
  endtask

  task automatic send_one(input logic [W-1:0] d);
    din = d; din_valid = 1'b1;
    cycle();
    din_valid = 1'b0;
  endtask

  initial begin
    logic rdy;
    bit   done;

    // Reset then idle
    reset = 1'b0;
    cycle();
    chk_en = 1'b1;
    cycle();
    reset = 1'b1;
    repeat (5) cycle();
    check("idle_busy",  m_busy, 0);
    check("idle_ready", m_ready, 1);

    // Single word, step held high
    step = 1'b1;
    clear_cols();
    send_one(8'hD6);
    repeat (10) cycle();
    check("d6_msb_word", col_m[7:0], 8'hD6);
    check("d6_lsb_word", col_l[7:0], 8'h6B);
    check("d6_bits",     cnt_sv, 8);
    check("d6_idle",     m_busy, 0);

    // Back-to-back words, second goes through the hold buffer
    clear_cols();
    send_one(8'hD6);
    din = 8'hA5; din_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      rdy = m_ready;
      cycle();
      if (rdy) done = 1'b1;
    end
    din_valid = 1'b0;
    check("b2b_accept_bound", int'(done), 1);
    repeat (20) cycle();
    check("b2b_stream",  col_m, 16'hD6A5);
    check("b2b_bits",    cnt_sv, 16);
    check("b2b_nogap",   last_sv - first_sv, 15);
    check("b2b_notrdy",  cnt_nr, 7);

    // Step throttled to every third cycle
    clear_cols();
    step = 1'b0;
    send_one(8'h81);
    for (int i = 0; i < 24; i++) begin
      step = ((i % 3) == 2);
      cycle();
    end
    step = 1'b0;
    repeat (3) cycle();
    check("thr_word", col_m[7:0], 8'h81);
    check("thr_bits", cnt_sv, 8);

    // LSB-first ordering
    step = 1'b1;
    clear_cols();
    send_one(8'h0B);
    repeat (10) cycle();
    check("lsb_0b_word", col_l[7:0], 8'hD0);
    check("msb_0b_word", col_m[7:0], 8'h0B);

    // Reset after the third bit with a word held
    send_one(8'hFF);
    din = 8'h0F; din_valid = 1'b1;
    cycle();
    din_valid = 1'b0;
    check("rst_held", m_ready, 0);
    repeat (2) cycle();
    reset = 1'b0;
    cycle();
    check("rst_sv",    m_sv, 0);
    check("rst_busy",  m_busy, 0);
    check("rst_ready", m_ready, 1);
    check("rst_sout",  m_sout, 0);
    reset = 1'b1;
    clear_cols();
    repeat (20) cycle();
    check("rst_nobits", cnt_sv, 0);

    // Randomized traffic, occasional resets
    for (int i = 0; i < 3000; i++) begin
      din       = W'($urandom);
      din_valid = ($urandom_range(0, 3) != 0);
      step      = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 199) != 0);
      cycle();
    end
    reset = 1'b1; din_valid = 1'b0; step = 1'b1;
    repeat (25) cycle();
    check("final_idle", m_busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
